// File: rtl/camo_cfg_pkg.sv
// Shared types, cell codes and checksum fold for the camouflage key loader.
// Pure definitions: no latency, no flow control.
package camo_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [1:0] CFG_PASS   = 2'b00;
    localparam logic [1:0] CFG_CONST1 = 2'b01;
    localparam logic [1:0] CFG_INV    = 2'b10;
    localparam logic [1:0] CFG_CONST0 = 2'b11;

    localparam int CFG_KEY_MAX = 64;

    // Zero-extended keys fold correctly since 2'b00 is the XOR identity.
    function automatic logic [1:0] cfg_chk(input logic [CFG_KEY_MAX-1:0] key);
        logic [1:0] acc;
        acc = 2'b00;
        for (int i = 0; i < CFG_KEY_MAX / 2; i++) begin
            acc = acc ^ key[2*i +: 2];
        end
        return acc;
    endfunction

endpackage

// File: rtl/camo_key_shreg.sv
// Shadow shift register and bit counter for one serial key frame.
// One bit per i_shift_en cycle; i_clr restarts the count and wins over a shift.
module camo_key_shreg #(
    parameter  int W  = 12,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_shift_en,
    input  logic         i_clr,
    input  logic         i_bit,
    output logic [W-1:0] o_shadow,
    output logic         o_last_bit
);

    logic [W-1:0]  r_shadow;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_shift_en) begin
            r_shadow <= {r_shadow[W-2:0], i_bit};
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign o_shadow   = r_shadow;
    assign o_last_bit = i_shift_en && !i_clr && (r_cnt == CW'(W - 1));

endmodule

// File: rtl/camo_key_loader.sv
// Serial key loader: commits a checksum-valid frame to cfg_o, locks out after MAX_FAIL bad frames.
// Result registered two cycles after the last bit; ready_o low outside SHIFT, gaps unbounded.
module camo_key_loader
    import camo_cfg_pkg::*;
#(
    parameter  int N_CELLS  = 5,
    parameter  int MAX_FAIL = 3,
    localparam int KEY_W    = 2 * N_CELLS,
    localparam int FW       = $clog2(MAX_FAIL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [KEY_W-1:0] cfg_o,
    output logic             cfg_valid_o,
    output logic             done_o,
    output logic             err_o,
    output logic             locked_o,
    output logic [FW-1:0]    fail_cnt_o
);

    localparam logic [KEY_W-1:0] CFG_SAFE = {N_CELLS{CFG_CONST0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clr;
    logic               w_shift_en;
    logic               w_last_bit;
    logic [KEY_W+1:0]   w_shadow;
    logic [KEY_W-1:0]   w_key;
    logic               w_chk_ok;
    logic [FW-1:0]      w_fail_inc;

    logic [KEY_W-1:0]   r_cfg;
    logic               r_cfg_valid;
    logic               r_done;
    logic               r_err;
    logic               r_locked;
    logic               r_ready;
    logic               r_busy;
    logic [FW-1:0]      r_fail;

    camo_key_shreg #(
        .W (KEY_W + 2)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift_en (w_shift_en),
        .i_clr      (w_clr),
        .i_bit      (bit_i),
        .o_shadow   (w_shadow),
        .o_last_bit (w_last_bit)
    );

    assign w_key      = w_shadow[KEY_W+1:2];
    assign w_chk_ok   = (cfg_chk({{(CFG_KEY_MAX - KEY_W){1'b0}}, w_key}) == w_shadow[1:0]);
    assign w_fail_inc = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + FW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_clr       = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A restart takes precedence over a bit offered in the same cycle.
                if (start_i) begin
                    w_clr = 1'b1;
                end else begin
                    w_shift_en = bit_valid_i;
                    if (w_last_bit) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (!w_chk_ok && (w_fail_inc == FW'(MAX_FAIL))) begin
                    w_state_nxt = LOCKED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED: begin
                w_state_nxt = LOCKED;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg       <= CFG_SAFE;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_fail      <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= (w_state_nxt == SHIFT);
            r_busy  <= (w_state_nxt == SHIFT) || (w_state_nxt == CHECK);
            if (r_state == CHECK) begin
                if (w_chk_ok) begin
                    r_cfg       <= w_key;
                    r_cfg_valid <= 1'b1;
                    r_fail      <= '0;
                    r_done      <= 1'b1;
                end else begin
                    r_fail <= w_fail_inc;
                    r_err  <= 1'b1;
                    if (w_fail_inc == FW'(MAX_FAIL)) begin
                        r_locked    <= 1'b1;
                        r_cfg       <= CFG_SAFE;
                        r_cfg_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign cfg_o       = r_cfg;
    assign cfg_valid_o = r_cfg_valid;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign locked_o    = r_locked;
    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign fail_cnt_o  = r_fail;

endmodule

// File: doc/camo_key_loader.md
Name: camo_key_loader

Overview:
Loads, checks and holds the 2-bit-per-cell configuration word that drives the key inputs of an obfuscated netlist (e.g. D_0..D_9 of a 5-cell camouflaged c432). Key bits arrive serially with a 2-bit checksum. The active configuration changes only after a full, checksum-valid frame. Repeated bad frames lock the block into a safe, non-functional configuration until reset.

Parameters:
N_CELLS, 5, number of camouflaged cells; KEY_W = 2*N_CELLS
MAX_FAIL, 3, consecutive bad frames before lockout (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  begin new frame (level sampled each cycle)
bit_valid_i  input  1  serial bit valid
bit_i  input  1  serial data, MSB first
ready_o  output  1  high in SHIFT; a bit transfers when bit_valid_i && ready_o
busy_o  output  1  high in SHIFT or CHECK
cfg_o  output  KEY_W  cell config; cell i = cfg_o[2i+1:2i], D_2i = cfg_o[2i], D_2i+1 = cfg_o[2i+1]
cfg_valid_o  output  1  cfg_o holds a committed key
done_o  output  1  one-cycle pulse: frame committed
err_o  output  1  one-cycle pulse: checksum mismatch
locked_o  output  1  sticky lockout
fail_cnt_o  output  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Cell code {D_2i+1, D_2i}: 00 = pass, 01 = const1, 10 = invert, 11 = const0.
- Reset (rst_n=0 at an edge): state IDLE; cfg_o all ones (every cell const0); cfg_valid_o, done_o, err_o, locked_o, ready_o, busy_o = 0; fail_cnt_o = 0; shadow register and bit counter = 0. Reset mid-frame discards the frame.
- Frame = KEY_W key bits (bit KEY_W-1 first), then chk[1], chk[0]. Total KEY_W+2 bits.
- Expected chk = XOR over all i of key[2i+1:2i].
- IDLE: start_i=1 -> SHIFT; bit counter cleared. bit_valid_i is ignored.
- SHIFT: each transfer shifts bit_i into a (KEY_W+2)-bit shadow register and increments the counter. The transfer of bit KEY_W+2 moves the state to CHECK. Gaps (bit_valid_i=0) are allowed indefinitely.
- start_i=1 in SHIFT aborts the frame and restarts it: counter = 0, state stays SHIFT. Any bit offered in that same cycle is dropped. This does not count as a failure.
- CHECK (exactly 1 cycle): ready_o = 0; start_i is ignored. Shadow checksum is compared with the computed chk.
  - Match: at the next edge cfg_o <= key part of shadow, cfg_valid_o <= 1, fail_cnt <= 0, done_o pulses; state -> IDLE.
  - Mismatch: cfg_o and cfg_valid_o are unchanged, fail_cnt increments, err_o pulses. If the new fail_cnt == MAX_FAIL: state -> LOCKED, locked_o <= 1, cfg_o <= all ones, cfg_valid_o <= 0. Otherwise state -> IDLE.
- Latency: last bit accepted in cycle t; CHECK in t+1; cfg_o, done_o or err_o registered visible in t+2. ready_o is low from t+1.
- cfg_o never changes during SHIFT: the previously committed key stays active.
- LOCKED: absorbing state. ready_o = busy_o = 0; start_i and bits are ignored; only reset exits.
- fail_cnt saturates at MAX_FAIL.
- done_o and err_o are never high together. All outputs are registered.

Decomposition:
- Package camo_cfg_pkg holds:
  - state enum {IDLE, SHIFT, CHECK, LOCKED}
  - code constants CFG_PASS = 2'b00, CFG_CONST1 = 2'b01, CFG_INV = 2'b10, CFG_CONST0 = 2'b11
  - function cfg_chk(key) returning the 2-bit XOR fold
- One sub-module, camo_key_shreg: shadow shift register plus bit counter, with inputs shift_en and clr and output last_bit.
- The FSM, check logic and output registers live in camo_key_loader.

Test Plan:
- Reset, then observe outputs -> cfg_o = 10'h3FF, cfg_valid_o = 0, locked_o = 0, ready_o = 0.
- start_i, then frame key 10'b10_01_11_00_10 + chk 10, one bit per cycle -> CHECK one cycle after the 12th bit; one cycle later cfg_o = 10'b1001110010, cfg_valid_o = 1, done_o high for 1 cycle, fail_cnt_o = 0.
- Same frame with bit_valid_i toggling 1/0 every cycle -> identical result. cfg_o keeps its previous value until the commit cycle.
- Key 10'b0000000000 with chk 01 -> err_o pulse, fail_cnt_o = 1, cfg_o unchanged (still the prior key), state IDLE.
- Three consecutive bad frames (MAX_FAIL = 3) -> after the third, locked_o = 1, cfg_o = 10'h3FF, cfg_valid_o = 0. A following valid frame is ignored and no done_o is seen. rst_n low for 1 cycle clears the lock.
- start_i reasserted after 6 bits, then a full valid 12-bit frame -> only the second frame commits and fail_cnt_o is unchanged. Separately, rst_n low mid-frame -> outputs return to reset values.
